// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply, restoring divide,
// WIDTH iterations per operation plus one sign-fixup cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] WD,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]      count;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  // Handshake: start is honoured only in IDLE; busy covers RUN and FIX; done pulses after FIX.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (count == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Launch-time operand conditioning (signed ops only when op[0] is 0).
  logic             sgn_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    sgn_op = ~op[0];
    a_neg  = sgn_op & SrcA[WIDTH-1];
    b_neg  = sgn_op & SrcB[WIDTH-1];
    a_mag  = a_neg ? -SrcA : SrcA;
    b_mag  = b_neg ? -SrcB : SrcB;
  end

  // One iteration of each algorithm; rem_sh is the WIDTH+1-bit partial remainder.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;

  always_comb begin
    mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opa} : '0);
    rem_sh  = {rem, quo[WIDTH-1]};
    rem_ge  = rem_sh[WIDTH] | (rem_sh[WIDTH-1:0] >= opb);
    prod_s  = neg_q ? -prod : prod;
    quo_s   = neg_q ? -quo : quo;
    rem_s   = neg_r ? -rem : rem;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      count  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      a_raw  <= '0;
      opa    <= '0;
      opb    <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            a_raw  <= SrcA;
            opa    <= a_mag;
            opb    <= b_mag;
            prod   <= {{WIDTH{1'b0}}, b_mag};
            rem    <= '0;
            quo    <= a_mag;
            count  <= '0;
            busy   <= 1'b1;
          end else begin
            if (hi_we) HI <= WD;
            if (lo_we) LO <= WD;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (is_div) begin
            rem <= rem_ge ? (rem_sh[WIDTH-1:0] - opb) : rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], rem_ge};
          end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
          end
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (!is_div) begin
            HI <= prod_s[2*WIDTH-1:WIDTH];
            LO <= prod_s[WIDTH-1:0];
          end else if (opb == '0) begin
            // Divide by zero: quotient saturates, remainder is the original dividend.
            HI <= a_raw;
            LO <= '1;
          end else begin
            HI <= rem_s;
            LO <= quo_s;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for MIPS MULT, MULTU, DIV and DIVU. It also implements MTHI/MTLO and owns the HI/LO registers.
- Sits directly downstream of the register file. It consumes RD1/RD2 as SrcA/SrcB.
- HI/LO feed the MFHI/MFLO path back into WD3 writeback.
- Asserts busy so the control unit can stall the PC while an operation runs.

Parameters:
- WIDTH, 32, operand width; also the iteration count per operation.

Ports:
- CLK  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch the operation selected by op; sampled only when busy=0.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcA  input  WIDTH  multiplicand / dividend (register file RD1).
- SrcB  input  WIDTH  multiplier / divisor (register file RD2).
- hi_we  input  1  MTHI write enable.
- lo_we  input  1  MTLO write enable.
- WD  input  WIDTH  MTHI/MTLO write data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when a result lands in HI/LO.
- HI  output  WIDTH  HI register: product upper half / remainder.
- LO  output  WIDTH  LO register: product lower half / quotient.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; HI=0, LO=0, busy=0, done=0.
  - Internal accumulators and count are cleared.
  - Reset mid-operation aborts it; no partial result is written.
- States: IDLE, RUN, FIX. All outputs are registered.
- IDLE, edge with start=1 (edge E0):
  - Latch op.
  - Convert signed operands to magnitudes; record result sign and remainder sign.
  - count=0, busy<=1, go to RUN.
- RUN: one iteration per edge; count increments.
  - Multiply: shift-add, 2*WIDTH-bit product accumulator.
  - Divide: restoring shift-subtract; WIDTH+1-bit partial remainder.
  - After WIDTH iterations (edge E32) go to FIX.
- FIX (edge E33):
  - Apply sign correction and write HI/LO.
  - done<=1 for exactly one cycle; busy<=0; go to IDLE.
- Latency:
  - busy is high for WIDTH+1 = 33 cycles (after E0 through E33).
  - New HI/LO are visible after E33.
  - A new start is accepted on the first edge after busy falls.
- Arithmetic rules:
  - MULT: signed 64-bit product. MULTU: unsigned product. HI = upper half, LO = lower half.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (DIV and DIVU): LO=all ones, HI=SrcA as latched. No exception; takes the full latency.
- Signed overflow, 0x80000000 / 0xFFFFFFFF under DIV: LO=0x80000000, HI=0.
- start while busy=1: ignored; the operation in flight continues undisturbed.
- hi_we/lo_we:
  - In IDLE with start=0: HI/LO<=WD on the edge. hi_we and lo_we together write both.
  - Ignored while busy=1 and on the start edge (start has priority).
- SrcA/SrcB are don't-care after E0; the unit must not re-sample them.
- HI/LO hold their value at all times except on the FIX edge and MTHI/MTLO writes.

Test Plan:
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF:
   - busy high for exactly 33 cycles; done pulses one cycle.
   - HI=0xFFFFFFFE, LO=0x00000001.
2. MULT −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. Divide corner cases:
   - DIVU 100 / 0 → LO=0xFFFFFFFF, HI=100.
   - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
4. Start MULTU 7×6; on cycle 10 pulse start with DIVU 9/3 and change SrcA/SrcB:
   - Second start is ignored.
   - Result is HI=0, LO=42 after E33.
5. MTHI WD=0x1234 and MTLO WD=0x5678 in IDLE → HI=0x1234, LO=0x5678 next edge.
   - Repeat the writes while busy → no change.
6. Assert rst at cycle 15 of a DIV:
   - HI/LO/busy/done drop to 0 immediately.
   - After release, a fresh MULTU 2×3 gives LO=6.
